// File: rtl/command_word_sequencer.sv
// 8259A-style initialization/operation command sequencer: detects completed bus
// writes, walks ICW1..ICW4, decodes OCW1..OCW3 and emits one-cycle strobes.
module command_word_sequencer #(
   parameter logic [7:0] MASK_RESET_VALUE = 8'h00
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       chip_select_n,
   input  logic       write_enable_n,
   input  logic       address,
   input  logic [7:0] data_bus_in,
   output logic       init_done,
   output logic [3:0] icw_pulse,
   output logic [2:0] ocw_pulse,
   output logic [4:0] vector_base,
   output logic       level_triggered,
   output logic       single_mode,
   output logic [7:0] cascade_config,
   output logic       microprocessor_mode,
   output logic       auto_eoi,
   output logic       buffer_master,
   output logic       buffered_mode,
   output logic       special_fully_nested,
   output logic [7:0] interrupt_mask,
   output logic [2:0] ocw2_command,
   output logic [2:0] ocw2_level,
   output logic       read_isr_select,
   output logic       special_mask_mode,
   output logic       poll_command
);

   typedef enum logic [2:0] {
      ST_UNINIT    = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       write_active_s, write_active_q, commit_s;
   logic       addr_q;
   logic [7:0] data_q;
   logic       is_icw1_s, is_ocw2_s, is_ocw3_s, ready_s;

   logic       init_done_q, init_done_d;
   logic [3:0] icw_pulse_q, icw_pulse_d;
   logic [2:0] ocw_pulse_q, ocw_pulse_d;
   logic [4:0] vector_base_q, vector_base_d;
   logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
   logic [7:0] cascade_q, cascade_d;
   logic [4:0] icw4_q, icw4_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] ocw2_cmd_q, ocw2_cmd_d, ocw2_lvl_q, ocw2_lvl_d;
   logic       ris_q, ris_d, smm_q, smm_d, poll_q, poll_d;

   assign write_active_s = ~chip_select_n & ~write_enable_n;
   // Commit on the trailing edge of a write, using the bus sampled on its last active cycle.
   assign commit_s  = ~write_active_s & write_active_q;
   assign is_icw1_s = ~addr_q & data_q[4];
   assign is_ocw2_s = ~addr_q & ~data_q[4] & ~data_q[3];
   assign is_ocw3_s = ~addr_q & ~data_q[4] & data_q[3];
   assign ready_s   = (state_q == ST_READY);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_active_q <= 1'b0;
         addr_q         <= 1'b0;
         data_q         <= 8'h00;
      end else begin
         write_active_q <= write_active_s;
         if (write_active_s) begin
            addr_q <= address;
            data_q <= data_bus_in;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_UNINIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (commit_s) begin
         if (is_icw1_s) begin
            state_d = ST_WAIT_ICW2;
         end else if (addr_q) begin
            case (state_q)
               ST_WAIT_ICW2: begin
                  if (!sngl_q)    state_d = ST_WAIT_ICW3;
                  else if (ic4_q) state_d = ST_WAIT_ICW4;
                  else            state_d = ST_READY;
               end
               ST_WAIT_ICW3: state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
               ST_WAIT_ICW4: state_d = ST_READY;
               default:      state_d = state_q;
            endcase
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      icw_pulse_d   = 4'b0000;
      ocw_pulse_d   = 3'b000;
      poll_d        = 1'b0;
      vector_base_d = vector_base_q;
      ltim_d        = ltim_q;
      sngl_d        = sngl_q;
      ic4_d         = ic4_q;
      cascade_d     = cascade_q;
      icw4_d        = icw4_q;
      mask_d        = mask_q;
      ocw2_cmd_d    = ocw2_cmd_q;
      ocw2_lvl_d    = ocw2_lvl_q;
      ris_d         = ris_q;
      smm_d         = smm_q;
      init_done_d   = (state_d == ST_READY);
      if (commit_s) begin
         if (is_icw1_s) begin
            icw_pulse_d = 4'b0001;
            ltim_d      = data_q[3];
            sngl_d      = data_q[1];
            ic4_d       = data_q[0];
            mask_d      = MASK_RESET_VALUE;
            smm_d       = 1'b0;
            ris_d       = 1'b0;
            if (!data_q[0]) icw4_d = 5'b00000;
            else            icw4_d = icw4_q;
            if (data_q[1])  cascade_d = 8'h00;
            else            cascade_d = cascade_q;
         end else if (addr_q) begin
            case (state_q)
               ST_WAIT_ICW2: begin
                  icw_pulse_d   = 4'b0010;
                  vector_base_d = data_q[7:3];
               end
               ST_WAIT_ICW3: begin
                  icw_pulse_d = 4'b0100;
                  cascade_d   = data_q;
               end
               ST_WAIT_ICW4: begin
                  icw_pulse_d = 4'b1000;
                  icw4_d      = data_q[4:0];
               end
               ST_READY: begin
                  ocw_pulse_d = 3'b001;
                  mask_d      = data_q;
               end
               default: icw_pulse_d = 4'b0000;
            endcase
         end else if (ready_s && is_ocw2_s) begin
            ocw_pulse_d = 3'b010;
            ocw2_cmd_d  = data_q[7:5];
            ocw2_lvl_d  = data_q[2:0];
         end else if (ready_s && is_ocw3_s) begin
            ocw_pulse_d = 3'b100;
            poll_d      = data_q[2];
            if (data_q[1]) ris_d = data_q[0];
            else           ris_d = ris_q;
            if (data_q[6]) smm_d = data_q[5];
            else           smm_d = smm_q;
         end else begin
            ocw_pulse_d = 3'b000;
         end
      end else begin
         icw_pulse_d = 4'b0000;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         init_done_q   <= 1'b0;
         icw_pulse_q   <= 4'b0000;
         ocw_pulse_q   <= 3'b000;
         poll_q        <= 1'b0;
         vector_base_q <= 5'b00000;
         ltim_q        <= 1'b0;
         sngl_q        <= 1'b0;
         ic4_q         <= 1'b0;
         cascade_q     <= 8'h00;
         icw4_q        <= 5'b00000;
         mask_q        <= MASK_RESET_VALUE;
         ocw2_cmd_q    <= 3'b000;
         ocw2_lvl_q    <= 3'b000;
         ris_q         <= 1'b0;
         smm_q         <= 1'b0;
      end else begin
         init_done_q   <= init_done_d;
         icw_pulse_q   <= icw_pulse_d;
         ocw_pulse_q   <= ocw_pulse_d;
         poll_q        <= poll_d;
         vector_base_q <= vector_base_d;
         ltim_q        <= ltim_d;
         sngl_q        <= sngl_d;
         ic4_q         <= ic4_d;
         cascade_q     <= cascade_d;
         icw4_q        <= icw4_d;
         mask_q        <= mask_d;
         ocw2_cmd_q    <= ocw2_cmd_d;
         ocw2_lvl_q    <= ocw2_lvl_d;
         ris_q         <= ris_d;
         smm_q         <= smm_d;
      end
   end

   assign init_done            = init_done_q;
   assign icw_pulse            = icw_pulse_q;
   assign ocw_pulse            = ocw_pulse_q;
   assign vector_base          = vector_base_q;
   assign level_triggered      = ltim_q;
   assign single_mode          = sngl_q;
   assign cascade_config       = cascade_q;
   assign microprocessor_mode  = icw4_q[0];
   assign auto_eoi             = icw4_q[1];
   assign buffer_master        = icw4_q[2];
   assign buffered_mode        = icw4_q[3];
   assign special_fully_nested = icw4_q[4];
   assign interrupt_mask       = mask_q;
   assign ocw2_command         = ocw2_cmd_q;
   assign ocw2_level           = ocw2_lvl_q;
   assign read_isr_select      = ris_q;
   assign special_mask_mode    = smm_q;
   assign poll_command         = poll_q;

endmodule

// File: tb/tb_command_word_sequencer.sv
// Randomized bench for command_word_sequencer against a queue-based model of the
// initialization word sequence and OCW decode.
module tb_command_word_sequencer;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       chip_select_n = 1'b1;
   logic       write_enable_n = 1'b1;
   logic       address = 1'b0;
   logic [7:0] data_bus_in = 8'h00;
   logic       init_done;
   logic [3:0] icw_pulse;
   logic [2:0] ocw_pulse;
   logic [4:0] vector_base;
   logic       level_triggered, single_mode;
   logic [7:0] cascade_config;
   logic       microprocessor_mode, auto_eoi, buffer_master, buffered_mode, special_fully_nested;
   logic [7:0] interrupt_mask;
   logic [2:0] ocw2_command, ocw2_level;
   logic       read_isr_select, special_mask_mode, poll_command;

   command_word_sequencer #(.MASK_RESET_VALUE(8'h00)) dut (
      .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
      .write_enable_n(write_enable_n), .address(address), .data_bus_in(data_bus_in),
      .init_done(init_done), .icw_pulse(icw_pulse), .ocw_pulse(ocw_pulse),
      .vector_base(vector_base), .level_triggered(level_triggered), .single_mode(single_mode),
      .cascade_config(cascade_config), .microprocessor_mode(microprocessor_mode),
      .auto_eoi(auto_eoi), .buffer_master(buffer_master), .buffered_mode(buffered_mode),
      .special_fully_nested(special_fully_nested), .interrupt_mask(interrupt_mask),
      .ocw2_command(ocw2_command), .ocw2_level(ocw2_level),
      .read_isr_select(read_isr_select), .special_mask_mode(special_mask_mode),
      .poll_command(poll_command)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: the ICW words still owed after ICW1 are kept as a queue of numbers.
   int         pending_q[$];
   bit         m_ready;
   logic [3:0] m_icw;
   logic [2:0] m_ocw;
   logic       m_poll;
   logic [4:0] m_vb;
   logic       m_ltim, m_sngl;
   logic [7:0] m_casc;
   logic [4:0] m_icw4;
   logic [7:0] m_mask;
   logic [2:0] m_cmd, m_lvl;
   logic       m_ris, m_smm;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      pending_q.delete();
      m_ready = 1'b0;
      m_icw = 4'h0; m_ocw = 3'h0; m_poll = 1'b0;
      m_vb = 5'h0; m_ltim = 1'b0; m_sngl = 1'b0; m_casc = 8'h00; m_icw4 = 5'h0;
      m_mask = 8'h00; m_cmd = 3'h0; m_lvl = 3'h0; m_ris = 1'b0; m_smm = 1'b0;
   endtask

   task automatic model_write(input logic a0, input logic [7:0] d);
      int w;
      m_icw = 4'h0; m_ocw = 3'h0; m_poll = 1'b0;
      if (!a0 && d[4]) begin
         pending_q.delete();
         pending_q.push_back(2);
         if (!d[1]) pending_q.push_back(3);
         if (d[0])  pending_q.push_back(4);
         m_ready = 1'b0;
         m_icw = 4'b0001;
         m_ltim = d[3]; m_sngl = d[1];
         m_mask = 8'h00; m_smm = 1'b0; m_ris = 1'b0;
         if (!d[0]) m_icw4 = 5'h0;
         if (d[1])  m_casc = 8'h00;
      end else if (a0) begin
         if (pending_q.size() > 0) begin
            w = pending_q.pop_front();
            m_icw = 4'(1 << (w - 1));
            if (w == 2)      m_vb = d[7:3];
            else if (w == 3) m_casc = d;
            else             m_icw4 = d[4:0];
            if (pending_q.size() == 0) m_ready = 1'b1;
         end else if (m_ready) begin
            m_mask = d;
            m_ocw = 3'b001;
         end
      end else if (m_ready) begin
         if (!d[3]) begin
            m_ocw = 3'b010; m_cmd = d[7:5]; m_lvl = d[2:0];
         end else begin
            m_ocw = 3'b100; m_poll = d[2];
            if (d[1]) m_ris = d[0];
            if (d[6]) m_smm = d[5];
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_value({tag, ".init_done"}, 32'(init_done), 32'(m_ready));
      check_value({tag, ".icw_pulse"}, 32'(icw_pulse), 32'(m_icw));
      check_value({tag, ".ocw_pulse"}, 32'(ocw_pulse), 32'(m_ocw));
      check_value({tag, ".poll"}, 32'(poll_command), 32'(m_poll));
      check_value({tag, ".vector_base"}, 32'(vector_base), 32'(m_vb));
      check_value({tag, ".ltim"}, 32'(level_triggered), 32'(m_ltim));
      check_value({tag, ".sngl"}, 32'(single_mode), 32'(m_sngl));
      check_value({tag, ".cascade"}, 32'(cascade_config), 32'(m_casc));
      check_value({tag, ".icw4"}, 32'({special_fully_nested, buffered_mode, buffer_master,
                                          auto_eoi, microprocessor_mode}), 32'(m_icw4));
      check_value({tag, ".mask"}, 32'(interrupt_mask), 32'(m_mask));
      check_value({tag, ".ris"}, 32'(read_isr_select), 32'(m_ris));
      check_value({tag, ".smm"}, 32'(special_mask_mode), 32'(m_smm));
      if (m_ocw[1]) begin
         check_value({tag, ".ocw2_cmd"}, 32'(ocw2_command), 32'(m_cmd));
         check_value({tag, ".ocw2_lvl"}, 32'(ocw2_level), 32'(m_lvl));
      end
   endtask

   // Called at a negedge; holds the write for 'hold' cycles with junk data before the
   // final byte, ends it by CS or WR rising, then checks the cycle after the commit.
   task automatic do_write(input string tag, input logic a0, input logic [7:0] d,
                           input int hold, input bit end_by_cs);
      chip_select_n = 1'b0; write_enable_n = 1'b0; address = a0;
      data_bus_in = (hold == 1) ? d : 8'($urandom);
      for (int i = 1; i < hold; i++) begin
         @(negedge clock);
         data_bus_in = (i == hold - 1) ? d : 8'($urandom);
      end
      @(negedge clock);
      check_value({tag, ".idle_icw"}, 32'(icw_pulse), 32'h0);
      check_value({tag, ".idle_ocw"}, 32'(ocw_pulse), 32'h0);
      check_value({tag, ".idle_poll"}, 32'(poll_command), 32'h0);
      if (end_by_cs) chip_select_n = 1'b1;
      else           write_enable_n = 1'b1;
      data_bus_in = 8'($urandom);
      @(negedge clock);
      model_write(a0, d);
      check_all(tag);
   endtask

   task automatic idle_reset(input string tag);
      chip_select_n = 1'b1; write_enable_n = 1'b1;
      #1 reset_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      model_reset();
      #2 check_all("reset");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_all("post_reset");

      do_write("pre_a0", 1'b1, 8'hFF, 1, 1'b0);
      do_write("pre_ocw2", 1'b0, 8'h20, 1, 1'b0);

      do_write("icw1_13", 1'b0, 8'h13, 1, 1'b0);
      do_write("icw2_20", 1'b1, 8'h20, 1, 1'b1);
      check_value("tp1.wait_icw4", 32'(init_done), 32'h0);
      do_write("icw4_03", 1'b1, 8'h03, 1, 1'b0);
      check_value("tp1.vb", 32'(vector_base), 32'h04);
      check_value("tp1.done", 32'(init_done), 32'h1);

      do_write("icw1_18", 1'b0, 8'h18, 2, 1'b0);
      do_write("icw2_40", 1'b1, 8'h40, 1, 1'b0);
      do_write("icw3_04", 1'b1, 8'h04, 1, 1'b0);
      check_value("tp2.casc", 32'(cascade_config), 32'h04);
      check_value("tp2.done", 32'(init_done), 32'h1);

      do_write("ocw1_f0", 1'b1, 8'hF0, 1, 1'b0);
      check_value("tp3.mask", 32'(interrupt_mask), 32'hF0);
      do_write("ocw2_20", 1'b0, 8'h20, 1, 1'b0);
      check_value("tp3.cmd", 32'(ocw2_command), 32'h1);
      do_write("ocw3_0b", 1'b0, 8'h0B, 1, 1'b1);
      do_write("ocw3_0c", 1'b0, 8'h0C, 1, 1'b0);
      check_value("tp3.poll", 32'(poll_command), 32'h1);
      check_value("tp3.ris", 32'(read_isr_select), 32'h1);
      do_write("ocw3_68", 1'b0, 8'h68, 1, 1'b0);
      check_value("tp3.smm", 32'(special_mask_mode), 32'h1);

      do_write("ocw1_55", 1'b1, 8'h55, 1, 1'b0);
      do_write("icw1_10", 1'b0, 8'h10, 1, 1'b0);
      do_write("icw2_08", 1'b1, 8'h08, 1, 1'b0);
      do_write("reinit_13", 1'b0, 8'h13, 1, 1'b0);
      check_value("tp4.mask", 32'(interrupt_mask), 32'h00);
      check_value("tp4.casc", 32'(cascade_config), 32'h00);
      check_value("tp4.done", 32'(init_done), 32'h0);

      do_write("hold5_icw2", 1'b1, 8'hA8, 5, 1'b0);
      check_value("tp5.vb", 32'(vector_base), 32'h15);
      idle_reset("reset_in_icw4");

      chip_select_n = 1'b0; write_enable_n = 1'b0; address = 1'b0; data_bus_in = 8'h13;
      @(negedge clock);
      #1 reset_n = 1'b0;
      model_reset();
      #1 check_all("reset_mid_write");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chip_select_n = 1'b1;
      @(negedge clock);
      model_write(1'b0, 8'h13);
      check_all("write_after_reset");

      for (int k = 0; k < 400; k++) begin
         logic [7:0] d;
         logic       a0;
         d  = 8'($urandom);
         a0 = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            a0 = 1'b0; d[4] = 1'b1;
         end else if (!a0) begin
            d[4] = 1'b0;
         end
         if ($urandom_range(0, 59) == 0) idle_reset("rnd_reset");
         do_write("rnd", a0, d, int'($urandom_range(1, 4)), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/command_word_sequencer.md
Name: command_word_sequencer

Overview:
- Clocked initialization/operation sequencer for the 8259A-style PIC.
- Sits behind the bus control logic: samples CS/WR/A0/data, detects completed write cycles, and walks the ICW1→ICW2→(ICW3)→(ICW4) sequence.
- Decodes OCW1–OCW3 once initialized, holds all configuration registers, and emits one-cycle command-word strobes to the priority/mask logic.

Parameters:
- MASK_RESET_VALUE, 8'h00, interrupt_mask value after reset and after every ICW1.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- chip_select_n  in  1  chip select, active low
- write_enable_n  in  1  write strobe, active low
- address  in  1  A0
- data_bus_in  in  8  write data D7..D0
- init_done  out  1  high in READY state
- icw_pulse  out  4  one-hot one-cycle strobe; bit0=ICW1 … bit3=ICW4 accepted
- ocw_pulse  out  3  one-hot one-cycle strobe; bit0=OCW1, bit1=OCW2, bit2=OCW3 accepted
- vector_base  out  5  ICW2 D7..D3
- level_triggered  out  1  ICW1 D3 (LTIM)
- single_mode  out  1  ICW1 D1 (SNGL)
- cascade_config  out  8  ICW3 byte
- microprocessor_mode  out  1  ICW4 D0
- auto_eoi  out  1  ICW4 D1
- buffer_master  out  1  ICW4 D2
- buffered_mode  out  1  ICW4 D3
- special_fully_nested  out  1  ICW4 D4
- interrupt_mask  out  8  OCW1 byte (IMR)
- ocw2_command  out  3  OCW2 {R,SL,EOI}; valid while ocw_pulse[1]
- ocw2_level  out  3  OCW2 D2..D0; valid while ocw_pulse[1]
- read_isr_select  out  1  0 = read IRR, 1 = read ISR
- special_mask_mode  out  1  SMM
- poll_command  out  1  one-cycle strobe, OCW3 with P=1

Behaviour:
- Write detection:
  - write_active = ~chip_select_n & ~write_enable_n; registered each clock as write_active_q.
  - While write_active is high, address and data_bus_in are captured every clock.
  - Commit occurs on the first edge where write_active=0 and write_active_q=1. Registers and state update at that edge. Strobes are high for exactly the following cycle.
  - Each write cycle produces exactly one commit. A write that ends by CS rising still commits.
- Classification of the captured byte:
  - A0=0 & D4=1 → ICW1.
  - A0=0 & D4=0 & D3=0 → OCW2.
  - A0=0 & D4=0 & D3=1 → OCW3.
  - A0=1 → ICW2/3/4 or OCW1, depending on state.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset → UNINIT.
- ICW1 (accepted in any state):
  - Next state WAIT_ICW2; init_done=0.
  - Latch LTIM, SNGL, IC4(D0). D7..D5 and D2 are ignored.
  - interrupt_mask=MASK_RESET_VALUE, special_mask_mode=0, read_isr_select=0.
  - If IC4=0: clear all ICW4 outputs.
  - If SNGL=1: cascade_config=0.
- WAIT_ICW2 + A0=1: latch vector_base. Next state: WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
- WAIT_ICW3 + A0=1: latch cascade_config. Next state: WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4 + A0=1: latch ICW4 bits → READY.
- READY:
  - A0=1 → OCW1; latch interrupt_mask.
  - OCW2 → pulse only; no stored state.
  - OCW3:
    - RR(D1)=1 → read_isr_select=RIS(D0).
    - ESMM(D6)=1 → special_mask_mode=SMM(D5).
    - P(D2)=1 → poll_command pulse.
    - ocw_pulse[2] fires regardless of field values.
- Ignored writes (no state change, no strobe):
  - Any A0=1 write in UNINIT.
  - OCW2/OCW3-classified writes in UNINIT or WAIT_ICWx.
- Reset values: state UNINIT, write_active_q=0, all strobes 0, interrupt_mask=MASK_RESET_VALUE, every other output 0.
- Async reset mid-sequence or mid-write:
  - Immediate return to reset values.
  - A write still held when reset releases commits normally at its trailing edge.
- Back-to-back writes separated by one inactive cycle must each commit.

Test Plan:
- ICW1=0x13, ICW2=0x20, ICW4=0x03 → icw_pulse 0001,0010,1000 (no 0100); vector_base=0x04, single_mode=1, auto_eoi=1, microprocessor_mode=1, cascade_config=0x00, init_done=1 after ICW4 commit.
- ICW1=0x18, ICW2=0x40, ICW3=0x04 → init_done=1 after ICW3; level_triggered=1, cascade_config=0x04, all ICW4 outputs 0.
- In READY: OCW1=0xF0, then A0=0 writes 0x20, 0x0B, 0x0C, 0x68:
  - OCW1 → interrupt_mask=0xF0, ocw_pulse=001 for one cycle.
  - 0x20 → ocw_pulse=010 with ocw2_command=001, ocw2_level=0.
  - 0x0B → read_isr_select=1.
  - 0x0C → poll_command one cycle, read_isr_select stays 1.
  - 0x68 → special_mask_mode=1.
- Re-init: in WAIT_ICW3 with interrupt_mask=0x55 from a prior session, write ICW1=0x13 → state WAIT_ICW2, init_done=0, interrupt_mask=0x00, cascade_config=0.
- Pre-init: A0=1 write 0xFF and A0=0 write 0x20 in UNINIT → no icw/ocw pulse, interrupt_mask stays 0x00.
- WR held low for 5 clocks with data changing each clock → single commit, using the data present on the last active cycle. Assert reset_n=0 during WAIT_ICW4 with bus idle → UNINIT, all outputs at reset values.
